mips150_mem_arbiter: RTL and testbench

- Shares one single-ported memory/bus port between the MIPS150 instruction-fetch requester (I) and the load/store requester (D).
- Sequences each access with a req/ack handshake and generates byte enables from the 2-bit MemWrite store encoding.
- Stalls the pipeline while an access is outstanding and flags bus timeouts and misaligned stores.
- Sits between the core's fetch/memory stages and the external memory controller.

---
 rtl/mips150_mem_arbiter_pkg.sv | 30 +++
 rtl/mips150_mem_arbiter_lane_gen.sv | 42 ++++
 rtl/mips150_mem_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_mips150_mem_arbiter.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips150_mem_arbiter_pkg.sv
// Shared definitions for the MIPS150 memory arbiter: FSM states, MemWrite
// store codes and grant identifiers.
package mips150_mem_arbiter_pkg;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IBUSY = 2'd1,
    DBUSY = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  // Which requester owns (or last owned) the memory port
  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } grant_e;

  // MemWrite encoding coming from the core's memory stage
  localparam logic [1:0] MW_LOAD = 2'b00;
  localparam logic [1:0] MW_BYTE = 2'b01;
  localparam logic [1:0] MW_HALF = 2'b10;
  localparam logic [1:0] MW_WORD = 2'b11;

  // Any non-load code writes memory
  function automatic logic is_store(input logic [1:0] we);
    return we != MW_LOAD;
  endfunction

endpackage

// File: rtl/mips150_mem_arbiter_lane_gen.sv
// Byte-lane generator: turns a MemWrite code, the low address bits and
// right-justified store data into byte enables, lane-replicated write data
// and an alignment fault flag. Purely combinational.
module mips150_mem_arbiter_lane_gen
  import mips150_mem_arbiter_pkg::*;
(
  input  logic [1:0]  we_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic        misaligned_o
);

  // Byte enables and alignment check; loads read the whole word
  always_comb begin
    be_o         = 4'b1111;
    misaligned_o = 1'b0;
    unique case (we_i)
      MW_BYTE: be_o = 4'b0001 << addr_lo_i;
      MW_HALF: begin
        be_o         = 4'b0011 << {addr_lo_i[1], 1'b0};
        misaligned_o = addr_lo_i[0];
      end
      MW_WORD: misaligned_o = (addr_lo_i != 2'b00);
      default: ;
    endcase
  end

  // Each lane picks the source byte so that whichever lanes are enabled
  // already hold the right data: bytes go everywhere, halves go to both
  // halves, words pass straight through.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign wdata_o[8*gi +: 8] = (we_i == MW_BYTE) ? wdata_i[7:0] :
                                  (we_i == MW_HALF) ? wdata_i[8*(gi%2) +: 8] :
                                                      wdata_i[8*gi +: 8];
    end
  endgenerate

endmodule

// File: rtl/mips150_mem_arbiter.sv
// MIPS150 memory arbiter: shares one single-ported memory between the
// instruction fetch (I) and load/store (D) requesters, with req/ack
// sequencing, byte-lane generation, a bus timeout and a sticky error flag.
module mips150_mem_arbiter
  import mips150_mem_arbiter_pkg::*;
#(
  parameter int          ADDR_W   = 14,
  parameter int          TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic              clk,
  input  logic              rst,
  // Fetch requester
  input  logic              i_req,
  input  logic [31:0]       i_addr,
  output logic [31:0]       i_rdata,
  output logic              i_valid,
  // Load/store requester
  input  logic              d_req,
  input  logic [1:0]        d_we,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic [31:0]       d_rdata,
  output logic              d_valid,
  // Pipeline status
  output logic              stall,
  output logic              bus_err,
  // Memory port
  output logic              mem_req,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
);

  // Value of the busy counter in the last BUSY cycle before giving up
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  arb_state_e        state_q;
  grant_e            last_grant_q;
  logic              mask_q;       // last_grant port is excluded this IDLE cycle
  logic [7:0]        cnt_q;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [3:0]        mem_be_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q;
  logic [31:0]       i_rdata_q;
  logic [31:0]       d_rdata_q;
  logic              i_valid_q;
  logic              d_valid_q;
  logic              bus_err_q;

  logic              i_pend;
  logic              d_pend;
  logic              grant_any;
  logic              pick_dport;
  logic [3:0]        lane_be;
  logic [31:0]       lane_wdata;
  logic              lane_misaligned;
  logic              d_is_store;

  // Only the word-address slice of each byte address reaches memory
  logic              unused_addr_bits;
  assign unused_addr_bits = ^{i_addr[1:0], i_addr[31:ADDR_W+2], d_addr[31:ADDR_W+2]};

  mips150_mem_arbiter_lane_gen u_lane_gen (
    .we_i         (d_we),
    .addr_lo_i    (d_addr[1:0]),
    .wdata_i      (d_wdata),
    .be_o         (lane_be),
    .wdata_o      (lane_wdata),
    .misaligned_o (lane_misaligned)
  );

  assign d_is_store = is_store(d_we);

  // Arbitration: mask the port that just completed, alternate on contention
  always_comb begin
    i_pend     = i_req & ~(mask_q & (last_grant_q == GNT_I));
    d_pend     = d_req & ~(mask_q & (last_grant_q == GNT_D));
    grant_any  = i_pend | d_pend;
    pick_dport = d_pend;
    if (i_pend && d_pend) begin
      pick_dport = (last_grant_q == GNT_I);
    end
  end

  // Arbiter FSM with all outputs registered
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_grant_q <= GNT_I;
      mask_q       <= 1'b0;
      cnt_q        <= 8'd0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_be_q     <= 4'b0000;
      mem_addr_q   <= '0;
      mem_wdata_q  <= 32'd0;
      i_rdata_q    <= 32'd0;
      d_rdata_q    <= 32'd0;
      i_valid_q    <= 1'b0;
      d_valid_q    <= 1'b0;
      bus_err_q    <= 1'b0;
    end else begin
      i_valid_q <= 1'b0;
      d_valid_q <= 1'b0;
      mask_q    <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (grant_any) begin
            cnt_q <= 8'd0;
            if (pick_dport) begin
              last_grant_q <= GNT_D;
              if (lane_misaligned) begin
                // Faulting store never touches memory; answer immediately
                state_q   <= RESP;
                d_valid_q <= 1'b1;
                d_rdata_q <= 32'd0;
                bus_err_q <= 1'b1;
              end else begin
                state_q     <= DBUSY;
                mem_req_q   <= 1'b1;
                mem_we_q    <= d_is_store;
                mem_be_q    <= lane_be;
                mem_addr_q  <= d_addr[ADDR_W+1:2];
                mem_wdata_q <= lane_wdata;
              end
            end else begin
              last_grant_q <= GNT_I;
              state_q      <= IBUSY;
              mem_req_q    <= 1'b1;
              mem_we_q     <= 1'b0;
              mem_be_q     <= 4'b1111;
              mem_addr_q   <= i_addr[ADDR_W+1:2];
              mem_wdata_q  <= 32'd0;
            end
          end
        end
        IBUSY, DBUSY: begin
          if (mem_ack) begin
            // An ack in the timeout cycle still counts as success
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            state_q   <= RESP;
            if (state_q == IBUSY) begin
              i_rdata_q <= mem_rdata;
              i_valid_q <= 1'b1;
            end else begin
              d_rdata_q <= mem_rdata;
              d_valid_q <= 1'b1;
            end
          end else if (cnt_q == TMO_LAST) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            bus_err_q <= 1'b1;
            state_q   <= RESP;
            if (state_q == IBUSY) begin
              i_rdata_q <= ERR_DATA;
              i_valid_q <= 1'b1;
            end else begin
              d_rdata_q <= ERR_DATA;
              d_valid_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        RESP: begin
          // Requester may still hold req this cycle; keep it out of the next grant
          state_q <= IDLE;
          mask_q  <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign i_rdata   = i_rdata_q;
  assign i_valid   = i_valid_q;
  assign d_rdata   = d_rdata_q;
  assign d_valid   = d_valid_q;
  assign bus_err   = bus_err_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  // Hold the pipeline while either requester is waiting for its completion
  assign stall = (i_req & ~i_valid_q) | (d_req & ~d_valid_q);

endmodule

// File: tb/tb_mips150_mem_arbiter.sv
// Scoreboard bench for mips150_mem_arbiter: stimulus pushes expected memory
// requests and read data into queues; a monitor pops and compares whenever
// the DUT raises mem_req, i_valid or d_valid.
module tb_mips150_mem_arbiter;

  localparam int ADDR_W = 14;

  localparam logic [1:0] LD = 2'b00;
  localparam logic [1:0] SB = 2'b01;
  localparam logic [1:0] SH = 2'b10;
  localparam logic [1:0] SW = 2'b11;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_req;
  logic [31:0]       i_addr;
  logic [31:0]       i_rdata;
  logic              i_valid;
  logic              d_req;
  logic [1:0]        d_we;
  logic [31:0]       d_addr;
  logic [31:0]       d_wdata;
  logic [31:0]       d_rdata;
  logic              d_valid;
  logic              stall;
  logic              bus_err;
  logic              mem_req;
  logic              mem_we;
  logic [3:0]        mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ack;

  always #5 clk = ~clk;

  mips150_mem_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_rdata   (i_rdata),
    .i_valid   (i_valid),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_valid   (d_valid),
    .stall     (stall),
    .bus_err   (bus_err),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_be    (mem_be),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  typedef struct {
    logic [13:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
  } mreq_t;

  typedef struct {
    logic [1:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] lane;
  } st_t;

  mreq_t       exp_mem[$];
  logic [31:0] exp_i[$];
  logic [31:0] exp_d[$];

  int errors      = 0;
  int checks      = 0;
  int rise_total  = 0;
  int high_total  = 0;
  int ack_delay   = 3;
  bit ack_en      = 1'b1;
  int inject_cnt  = 0;

  // Memory contents seen by the responder (one special word for the fetch test)
  function automatic logic [31:0] mem_fn(input logic [13:0] a);
    if (a == 14'h041) return 32'h2402_0005;
    return {16'hC0DE, 2'b00, a};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic push_mem(input logic [13:0] a, input logic [3:0] be, input logic we,
                          input logic [31:0] wd);
    mreq_t e;
    e.addr = a; e.be = be; e.we = we; e.wdata = wd;
    exp_mem.push_back(e);
  endtask

  // Memory responder: acks after ack_delay cycles of mem_req, or on injection
  task automatic responder();
    int busy = 0;
    int seen = 0;
    forever begin
      @(posedge clk); #1;
      mem_ack = 1'b0;
      if (inject_cnt != seen) begin
        seen      = inject_cnt;
        mem_ack   = 1'b1;
        mem_rdata = 32'h0BAD_0ACC;
      end else if (mem_req && ack_en) begin
        busy++;
        if (busy >= ack_delay) begin
          mem_ack   = 1'b1;
          mem_rdata = mem_fn(mem_addr);
          busy      = 0;
        end
      end else begin
        busy = 0;
      end
    end
  endtask

  // Monitor: compares every new memory request and every valid pulse
  task automatic monitor();
    logic  prev_req = 1'b0;
    mreq_t e;
    forever begin
      @(negedge clk);
      if (mem_req) high_total++;
      if (mem_req && !prev_req) begin
        rise_total++;
        if (exp_mem.size() == 0) begin
          checks++; errors++;
          $display("FAIL mem_req: unexpected request addr=%h be=%h", mem_addr, mem_be);
        end else begin
          e = exp_mem.pop_front();
          chk("mem_addr", 32'(mem_addr), 32'(e.addr));
          chk("mem_be", 32'(mem_be), 32'(e.be));
          chk("mem_we", 32'(mem_we), 32'(e.we));
          if (e.we) chk("mem_wdata", mem_wdata, e.wdata);
        end
      end
      prev_req = mem_req;
      if (i_valid && d_valid) begin
        checks++; errors++;
        $display("FAIL valid_overlap: i_valid=1 d_valid=1 required not both");
      end
      if (i_valid) begin
        if (exp_i.size() == 0) begin
          checks++; errors++;
          $display("FAIL i_valid: unexpected pulse rdata=%h", i_rdata);
        end else chk("i_rdata", i_rdata, exp_i.pop_front());
      end
      if (d_valid) begin
        if (exp_d.size() == 0) begin
          checks++; errors++;
          $display("FAIL d_valid: unexpected pulse rdata=%h", d_rdata);
        end else chk("d_rdata", d_rdata, exp_d.pop_front());
      end
    end
  endtask

  task automatic req_i(input logic [31:0] addr, input int bound, output bit stall_ok);
    bit got = 1'b0;
    stall_ok = 1'b1;
    i_addr = addr;
    i_req  = 1'b1;
    for (int n = 0; n < bound && !got; n++) begin
      @(negedge clk);
      if (i_valid) got = 1'b1;
      else if (!stall) stall_ok = 1'b0;
    end
    @(posedge clk); #1;
    i_req = 1'b0;
    if (!got) begin
      checks++; errors++;
      $display("FAIL i_wait: no i_valid within %0d cycles for addr %h", bound, addr);
    end
  endtask

  task automatic req_d(input logic [1:0] we, input logic [31:0] addr,
                       input logic [31:0] wdata, input int bound);
    bit got = 1'b0;
    d_we    = we;
    d_addr  = addr;
    d_wdata = wdata;
    d_req   = 1'b1;
    for (int n = 0; n < bound && !got; n++) begin
      @(negedge clk);
      if (d_valid) got = 1'b1;
    end
    @(posedge clk); #1;
    d_req = 1'b0;
    if (!got) begin
      checks++; errors++;
      $display("FAIL d_wait: no d_valid within %0d cycles for addr %h", bound, addr);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_mem_req"},   32'(mem_req),   32'd0);
    chk({tag, "_mem_we"},    32'(mem_we),    32'd0);
    chk({tag, "_mem_be"},    32'(mem_be),    32'd0);
    chk({tag, "_mem_addr"},  32'(mem_addr),  32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata,      32'd0);
    chk({tag, "_i_valid"},   32'(i_valid),   32'd0);
    chk({tag, "_d_valid"},   32'(d_valid),   32'd0);
    chk({tag, "_bus_err"},   32'(bus_err),   32'd0);
    chk({tag, "_i_rdata"},   i_rdata,        32'd0);
    chk({tag, "_d_rdata"},   d_rdata,        32'd0);
  endtask

  initial begin
    st_t st_tab[5];
    bit  sok;
    int  r0;
    int  h0;

    rst = 1'b0; i_req = 1'b0; i_addr = 32'd0;
    d_req = 1'b0; d_we = LD; d_addr = 32'd0; d_wdata = 32'd0;
    mem_rdata = 32'd0; mem_ack = 1'b0;

    fork
      responder();
      monitor();
      begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
      end
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("rst");
    chk("rst_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Fetch only, ack in the third mem_req cycle
    ack_delay = 3;
    push_mem(14'h041, 4'hF, 1'b0, 32'd0);
    exp_i.push_back(32'h2402_0005);
    req_i(32'h0000_0104, 50, sok);
    chk("fetch_stall_until_valid", 32'(sok), 32'd1);

    // Simultaneous I+D after reset: D first, then strict alternation
    do_reset();
    ack_delay = 2;
    for (int k = 0; k < 10; k++) begin
      push_mem(14'(32'h402 + 2*k), 4'hF, 1'b0, 32'd0);
      push_mem(14'(32'h040 + k),   4'hF, 1'b0, 32'd0);
      exp_d.push_back(mem_fn(14'(32'h402 + 2*k)));
      exp_i.push_back(mem_fn(14'(32'h040 + k)));
    end
    fork
      begin
        for (int k = 0; k < 10; k++) req_d(LD, 32'h0000_1008 + 32'(8*k), 32'd0, 100);
      end
      begin
        bit s;
        for (int k = 0; k < 10; k++) req_i(32'h0000_0100 + 32'(4*k), 100, s);
      end
    join

    // Aligned stores: byte lanes and replicated data
    st_tab[0] = '{SB, 32'h0000_2003, 32'h0000_00AB, 4'b1000, 32'hABAB_ABAB};
    st_tab[1] = '{SB, 32'h0000_2001, 32'hFFFF_FF5A, 4'b0010, 32'h5A5A_5A5A};
    st_tab[2] = '{SH, 32'h0000_2002, 32'h8765_1234, 4'b1100, 32'h1234_1234};
    st_tab[3] = '{SH, 32'h0000_2000, 32'h0000_BEEF, 4'b0011, 32'hBEEF_BEEF};
    st_tab[4] = '{SW, 32'h0000_2004, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D};
    ack_delay = 1;
    for (int k = 0; k < 5; k++) begin
      push_mem(st_tab[k].addr[15:2], st_tab[k].be, 1'b1, st_tab[k].lane);
      exp_d.push_back(mem_fn(st_tab[k].addr[15:2]));
      req_d(st_tab[k].we, st_tab[k].addr, st_tab[k].wdata, 50);
    end
    chk("bus_err_clean", 32'(bus_err), 32'd0);

    // Misaligned stores: no memory access, d_rdata=0, bus_err sticky
    r0 = rise_total;
    exp_d.push_back(32'd0);
    req_d(SH, 32'h0000_3001, 32'h0000_1111, 20);
    chk("misaligned_sh_bus_err", 32'(bus_err), 32'd1);
    exp_d.push_back(32'd0);
    req_d(SW, 32'h0000_3002, 32'h2222_2222, 20);
    chk("misaligned_no_mem_req", 32'(rise_total - r0), 32'd0);
    push_mem(14'h0C00, 4'hF, 1'b0, 32'd0);
    exp_d.push_back(mem_fn(14'h0C00));
    req_d(LD, 32'h0000_3000, 32'd0, 50);
    chk("bus_err_sticky", 32'(bus_err), 32'd1);

    // Timeout: never ack
    do_reset();
    ack_en = 1'b0;
    push_mem(14'h1000, 4'hF, 1'b0, 32'd0);
    exp_d.push_back(32'hDEAD_BEEF);
    h0 = high_total;
    req_d(LD, 32'h0000_4000, 32'd0, 600);
    chk("timeout_busy_cycles", 32'(high_total - h0), 32'd255);
    chk("timeout_bus_err", 32'(bus_err), 32'd1);

    // Late ack in IDLE is ignored, then a normal access completes
    r0 = rise_total;
    @(posedge clk); #1;
    inject_cnt++;
    repeat (4) @(negedge clk);
    chk("late_ack_no_req", 32'(rise_total - r0), 32'd0);
    chk("late_ack_d_rdata", d_rdata, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    ack_en = 1'b1;
    push_mem(14'h1001, 4'hF, 1'b0, 32'd0);
    exp_d.push_back(mem_fn(14'h1001));
    req_d(LD, 32'h0000_4004, 32'd0, 50);

    // Reset while DBUSY abandons the access
    ack_en = 1'b0;
    push_mem(14'h1400, 4'hF, 1'b1, 32'h1122_3344);
    d_we = SW; d_addr = 32'h0000_5000; d_wdata = 32'h1122_3344; d_req = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("pre_reset_mem_req", 32'(mem_req), 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check_reset("rst_mid");
    @(posedge clk); #1;
    d_req = 1'b0;
    rst = 1'b1;
    r0 = rise_total;
    inject_cnt++;
    repeat (5) @(negedge clk);
    chk("post_reset_no_req", 32'(rise_total - r0), 32'd0);
    chk("post_reset_d_rdata", d_rdata, 32'd0);

    chk("exp_mem_drained", 32'(exp_mem.size()), 32'd0);
    chk("exp_i_drained", 32'(exp_i.size()), 32'd0);
    chk("exp_d_drained", 32'(exp_d.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
